// File: rtl/regfile_pkg.sv
// Shared constants for the single-cycle datapath register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned NUM_REGS       = 2 ** DEF_ADDR_WIDTH;

  // Architectural register indices.
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_SP   = 29;
  localparam int unsigned REG_RA   = 31;

endpackage : regfile_pkg

// File: rtl/register_file_read_port.sv
// One combinational read port: storage mux, r0 override, optional write bypass.
module register_file_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned BYPASS_EN  = 1
) (
  input  logic [(2**ADDR_WIDTH-1)*DATA_WIDTH-1:0] storage,
  input  logic [ADDR_WIDTH-1:0]                   addr,
  input  logic                                    wr_en,
  input  logic [ADDR_WIDTH-1:0]                   wr_addr,
  input  logic [DATA_WIDTH-1:0]                   wr_data,
  output logic [DATA_WIDTH-1:0]                   data
);

  localparam int unsigned N_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] stored_c;
  logic                  hit_c;
  logic                  is_zero_c;

  // Select the stored word; storage slot 0 holds register 1.
  always_comb begin
    stored_c = '0;
    for (int unsigned i = 1; i < N_REGS; i++) begin
      if (addr == ADDR_WIDTH'(i)) begin
        stored_c = storage[(i-1)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Register 0 is a hard-wired constant rather than storage.
  always_comb begin
    is_zero_c = (addr == ADDR_WIDTH'(REG_ZERO));
  end

  // Same-cycle write to the register being read; wr_en already excludes reset and r0.
  always_comb begin
    hit_c = wr_en && (wr_addr == addr);
  end

  // Final port value: r0 override wins, then bypass, then stored word.
  always_comb begin
    data = stored_c;
    if ((BYPASS_EN != 0) && hit_c) begin
      data = wr_data;
    end
    if (is_zero_c) begin
      data = '0;
    end
  end

endmodule : register_file_read_port

// File: rtl/register_file.sv
// 32-entry register file: two async read ports, one sync write port, one debug read port.
module register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned WRITE_BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  input  logic [ADDR_WIDTH-1:0] dbgReg,
  output logic [DATA_WIDTH-1:0] dbgData
);

  localparam int unsigned N_REGS = 2 ** ADDR_WIDTH;

  // Registers 1..N_REGS-1; register 0 has no storage.
  logic [N_REGS-1:1][DATA_WIDTH-1:0] regs_q;
  logic                              wr_en_c;

  // Effective write strobe: r0 writes are dropped, and reset masks both write and bypass.
  always_comb begin
    wr_en_c = rst_n && regWrite && (writeReg != ADDR_WIDTH'(REG_ZERO));
  end

  // Storage update; async clear of every register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      for (int unsigned i = 1; i < N_REGS; i++) begin
        if (wr_en_c && (writeReg == ADDR_WIDTH'(i))) begin
          regs_q[i] <= writeData;
        end
      end
    end
  end

  register_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS_EN  (WRITE_BYPASS)
  ) u_rd1 (
    .storage (regs_q),
    .addr    (readReg1),
    .wr_en   (wr_en_c),
    .wr_addr (writeReg),
    .wr_data (writeData),
    .data    (readData1)
  );

  register_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS_EN  (WRITE_BYPASS)
  ) u_rd2 (
    .storage (regs_q),
    .addr    (readReg2),
    .wr_en   (wr_en_c),
    .wr_addr (writeReg),
    .wr_data (writeData),
    .data    (readData2)
  );

  // Debug port always shows committed state.
  register_file_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS_EN  (0)
  ) u_dbg (
    .storage (regs_q),
    .addr    (dbgReg),
    .wr_en   (wr_en_c),
    .wr_addr (writeReg),
    .wr_data (writeData),
    .data    (dbgData)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed bench: one bypassing and one non-bypassing register file on shared stimulus.
module tb_register_file;
  import regfile_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [4:0]  dbgReg;
  logic [31:0] rd1_b, rd2_b, dbg_b;
  logic [31:0] rd1_n, rd2_n, dbg_n;

  int checks;
  int passed;

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WRITE_BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .writeReg(writeReg),
    .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
    .readData1(rd1_b), .readData2(rd2_b), .dbgReg(dbgReg), .dbgData(dbg_b)
  );

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WRITE_BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .writeReg(writeReg),
    .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
    .readData1(rd1_n), .readData2(rd2_n), .dbgReg(dbgReg), .dbgData(dbg_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    regWrite  = 1'b1;
    writeReg  = a;
    writeData = d;
    @(posedge clk);
    #1;
    regWrite = 1'b0;
  endtask

  task automatic test_reset;
    readReg1 = 5'(REG_SP); readReg2 = 5'(REG_RA); dbgReg = 5'd1;
    #1;
    checks++;
    if (rd1_b !== 32'h0 || rd2_b !== 32'h0 || dbg_b !== 32'h0)
      $display("FAIL reset_outputs: got %h %h %h want 0 0 0", rd1_b, rd2_b, dbg_b);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    do_write(5'd5, 32'hDEADBEEF);
    readReg1 = 5'd5;
    #1;
    checks++;
    if (rd1_b !== 32'hDEADBEEF) $display("FAIL reset_prewrite: got %h want deadbeef", rd1_b);
    else passed++;
    // Pulse reset mid-cycle, away from any clock edge
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rd1_b !== 32'h0 || rd1_n !== 32'h0)
      $display("FAIL reset_async_clear: got %h/%h want 0", rd1_b, rd1_n);
    else passed++;
    // Bypass must be suppressed while in reset
    regWrite = 1'b1; writeReg = 5'd5; writeData = 32'hCAFEF00D;
    #1;
    checks++;
    if (rd1_b !== 32'h0) $display("FAIL reset_no_bypass: got %h want 0", rd1_b);
    else passed++;
    regWrite = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (rd1_b !== 32'h0) $display("FAIL reset_stays_clear: got %h want 0", rd1_b);
    else passed++;
  endtask

  task automatic test_basic;
    do_write(5'd8, 32'h12345678);
    readReg1 = 5'd8; readReg2 = 5'd8; dbgReg = 5'd8;
    #1;
    checks++;
    if (rd1_b !== 32'h12345678) $display("FAIL basic_rd1: got %h want 12345678", rd1_b);
    else passed++;
    checks++;
    if (rd2_b !== 32'h12345678) $display("FAIL basic_rd2: got %h want 12345678", rd2_b);
    else passed++;
    checks++;
    if (dbg_b !== 32'h12345678) $display("FAIL basic_dbg: got %h want 12345678", dbg_b);
    else passed++;
    checks++;
    if (rd1_n !== 32'h12345678) $display("FAIL basic_nb_rd1: got %h want 12345678", rd1_n);
    else passed++;
  endtask

  task automatic test_zero;
    do_write(5'd0, 32'hFFFFFFFF);
    readReg1 = 5'd0; readReg2 = 5'd0; dbgReg = 5'd0;
    #1;
    checks++;
    if (rd1_b !== 32'h0 || rd2_b !== 32'h0) $display("FAIL zero_read: got %h %h want 0", rd1_b, rd2_b);
    else passed++;
    checks++;
    if (dbg_b !== 32'h0) $display("FAIL zero_dbg: got %h want 0", dbg_b);
    else passed++;
    // r0 must not bypass even while a write to it is presented
    @(negedge clk);
    regWrite = 1'b1; writeReg = 5'd0; writeData = 32'hFFFFFFFF;
    #1;
    checks++;
    if (rd1_b !== 32'h0) $display("FAIL zero_no_bypass: got %h want 0", rd1_b);
    else passed++;
    @(posedge clk);
    #1;
    regWrite = 1'b0;
  endtask

  task automatic test_bypass;
    do_write(5'd3, 32'h00000011);
    @(negedge clk);
    regWrite = 1'b1; writeReg = 5'd3; writeData = 32'h00000022;
    readReg1 = 5'd3; readReg2 = 5'd3; dbgReg = 5'd3;
    #1;
    checks++;
    if (rd1_b !== 32'h22 || rd2_b !== 32'h22)
      $display("FAIL bypass_both_ports: got %h %h want 22 22", rd1_b, rd2_b);
    else passed++;
    checks++;
    if (dbg_b !== 32'h11) $display("FAIL bypass_dbg_old: got %h want 11", dbg_b);
    else passed++;
    checks++;
    if (rd1_n !== 32'h11 || rd2_n !== 32'h11)
      $display("FAIL nobypass_before: got %h %h want 11 11", rd1_n, rd2_n);
    else passed++;
    @(posedge clk);
    #1;
    regWrite = 1'b0;
    #1;
    checks++;
    if (rd1_n !== 32'h22) $display("FAIL nobypass_after: got %h want 22", rd1_n);
    else passed++;
    checks++;
    if (dbg_b !== 32'h22 || rd1_b !== 32'h22)
      $display("FAIL bypass_after: got dbg %h rd1 %h want 22", dbg_b, rd1_b);
    else passed++;
  endtask

  task automatic test_reset_mid_write;
    @(negedge clk);
    regWrite = 1'b1; writeReg = 5'd10; writeData = 32'h000000AA;
    readReg1 = 5'd10; dbgReg = 5'd3;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    regWrite = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (rd1_b !== 32'h0) $display("FAIL reset_write_lost: got %h want 0", rd1_b);
    else passed++;
    checks++;
    if (dbg_b !== 32'h0) $display("FAIL reset_clears_r3: got %h want 0", dbg_b);
    else passed++;
    do_write(5'd10, 32'h00000055);
    #1;
    checks++;
    if (rd1_b !== 32'h55) $display("FAIL write_after_reset: got %h want 55", rd1_b);
    else passed++;
  endtask

  task automatic test_sweep;
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i) * 32'h01010101);
    @(negedge clk);
    regWrite = 1'b0; writeReg = 5'd7; writeData = 32'h0;
    @(posedge clk);
    #1;
    readReg1 = 5'd7;
    #1;
    checks++;
    if (rd1_b !== 32'h07070707) $display("FAIL write_disable_r7: got %h want 07070707", rd1_b);
    else passed++;
    for (int i = 1; i < 32; i++) begin
      logic [31:0] exp;
      exp = 32'(i) * 32'h01010101;
      readReg1 = 5'(i); readReg2 = 5'(i); dbgReg = 5'(i);
      #1;
      checks++;
      if (rd1_b !== exp || rd2_b !== exp || dbg_b !== exp || rd1_n !== exp)
        $display("FAIL sweep_r%0d: got %h %h %h %h want %h", i, rd1_b, rd2_b, dbg_b, rd1_n, exp);
      else passed++;
    end
  endtask

  initial begin
    checks = 0; passed = 0;
    rst_n = 1'b0; regWrite = 1'b0; writeReg = '0; writeData = '0;
    readReg1 = '0; readReg2 = '0; dbgReg = '0;
    test_reset();
    test_basic();
    test_zero();
    test_bypass();
    test_reset_mid_write();
    test_sweep();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_register_file

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry general-purpose register file for the single-cycle datapath.
- Sits directly upstream of the 32-bit ALU-source and write-back muxes: readData1 feeds the ALU; readData2 feeds the ALUSrc mux input zero.
- The write address arrives from the RegDst 5-bit mux; writeData arrives from the MemToReg 32-bit mux.
- Two asynchronous read ports, one synchronous write port, plus a debug read port for benches.

Parameters:
- DATA_WIDTH, 32, width of each register and of every data port.
- ADDR_WIDTH, 5, register address width; register count is 2**ADDR_WIDTH.
- WRITE_BYPASS, 1, 1 = a read of the register being written this cycle returns writeData; 0 = it returns the old stored value.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset; clears every register.
- regWrite  input  1  write enable, sampled on the rising edge of clk.
- writeReg  input  ADDR_WIDTH  write address, from the RegDst mux.
- writeData  input  DATA_WIDTH  write data, from the MemToReg mux.
- readReg1  input  ADDR_WIDTH  read-port-1 address (rs).
- readReg2  input  ADDR_WIDTH  read-port-2 address (rt).
- readData1  output  DATA_WIDTH  contents of readReg1.
- readData2  output  DATA_WIDTH  contents of readReg2.
- dbgReg  input  ADDR_WIDTH  debug read address.
- dbgData  output  DATA_WIDTH  contents of dbgReg; never bypassed.

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is asynchronous and active-low (rst_n); clock port is clk.
  - rst_n low → all registers clear to 0 immediately, without waiting for a clock edge.
- Write port:
  - Write occurs on the rising edge of clk when rst_n=1, regWrite=1 and writeReg!=0.
  - writeReg==0 is silently dropped: register 0 stays 0 forever.
  - regWrite=0 → no state change.
- Read ports:
  - Purely combinational, zero-cycle latency, no handshake.
  - Address 0 always reads 0 on every port.
- Bypass:
  - Active when WRITE_BYPASS=1, rst_n=1, regWrite=1, writeReg!=0 and readRegN==writeReg.
  - In that case readDataN = writeData in the same cycle.
  - readReg1 and readReg2 may both match writeReg; both ports bypass.
  - When WRITE_BYPASS=0, the read shows the old value until the edge and the new value after it.
- Reset values of outputs:
  - While rst_n=0, readData1, readData2 and dbgData are all 0.
  - Bypass is suppressed while rst_n=0.
- Reset mid-operation:
  - rst_n falling in the same cycle as a pending write → the write is lost and the register reads 0.
  - rst_n rising → the first write takes effect on the first rising edge of clk with rst_n=1.
- Width rules:
  - No arithmetic.
  - Data is stored and returned bit-exact.
  - No sign or zero extension.
- Storage: one DATA_WIDTH-bit flop vector per register, 1..2**ADDR_WIDTH-1. Register 0 is not implemented as storage; it is a constant.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH defaults.
  - NUM_REGS.
  - REG_ZERO=0.
  - Named register indices used by benches: REG_SP=29, REG_RA=31.
- Sub-module register_file_read_port:
  - Contents: address decode/mux over the storage vector, the zero-register override, and the optional bypass compare.
  - Instantiation: three times.
    - The two data ports use bypass per WRITE_BYPASS.
    - The debug port is instantiated with bypass forced off.

Test Plan:
- Reset clear: write 32'hDEADBEEF to reg 5, then pulse rst_n low mid-cycle for 3 ns → readData1 with readReg1=5 goes to 0 immediately, before any clock edge.
- Basic write/read: regWrite=1, writeReg=8, writeData=32'h12345678, one edge; then readReg1=8, readReg2=8 → both ports read 32'h12345678; dbgReg=8 also reads 32'h12345678.
- Zero register: regWrite=1, writeReg=0, writeData=32'hFFFFFFFF, one edge → readData1 with readReg1=0 is 0; dbgData with dbgReg=0 is 0.
- Bypass, WRITE_BYPASS=1: reg 3 holds 32'h00000011; in the same cycle drive writeReg=3, writeData=32'h00000022, readReg1=3, readReg2=3 → both ports show 32'h22 before the edge; dbgData shows 32'h11 until the edge.
- No bypass, WRITE_BYPASS=0: same stimulus → readData1 shows 32'h11 before the edge and 32'h22 after it.
- Write disable plus full sweep:
  - Write value i*32'h01010101 to regs 1..31, then one more edge with regWrite=0, writeReg=7, writeData=0.
  - Required: reg 7 still holds 32'h07070707.
  - Required: all 31 registers read back correctly on both ports.
